dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane.sv | 55 +++++
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Size/alignment rejection; the range check lives in the controller.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian lane logic: extracts a byte/half/word from a memory word with
// sign or zero extension, and merges right-aligned store data into that word.
module dmem_lane
  import dmem_pkg::*;
#(
  parameter int S = 32
) (
  input  logic [S-1:0] old_i,
  input  logic [S-1:0] new_i,
  input  logic [1:0]   size_i,
  input  logic [1:0]   off_i,
  input  logic         uns_i,
  output logic [S-1:0] merged_o,
  output logic [S-1:0] ext_o
);

  logic [4:0]   sh;
  logic [S-1:0] shifted;
  logic [S-1:0] mask;
  logic [S-1:0] ins;

  always_comb begin
    sh       = {off_i, 3'b000};
    shifted  = old_i >> sh;
    mask     = '0;
    ins      = '0;
    ext_o    = '0;
    case (size_i)
      SZ_BYTE: begin
        mask  = {{(S-8){1'b0}}, 8'hFF} << sh;
        ins   = {{(S-8){1'b0}}, new_i[7:0]} << sh;
        ext_o = uns_i ? {{(S-8){1'b0}}, shifted[7:0]}
                      : {{(S-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        mask  = {{(S-16){1'b0}}, 16'hFFFF} << sh;
        ins   = {{(S-16){1'b0}}, new_i[15:0]} << sh;
        ext_o = uns_i ? {{(S-16){1'b0}}, shifted[15:0]}
                      : {{(S-16){shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        mask  = '1;
        ins   = new_i;
        ext_o = shifted;  // offset is zero for legal word accesses
      end
      default: begin
        mask  = '0;
        ins   = '0;
        ext_o = '0;
      end
    endcase
    merged_o = (old_i & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// CPU load/store front end for a single-port word memory; sub-word stores are
// done as read-modify-write. All outputs are registered; one request in flight.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int S  = 32,
  parameter  int L  = 256,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [S-1:0]  req_wdata,
  output logic          rsp_valid,
  output logic [S-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_a,
  output logic [S-1:0]  mem_din,
  input  logic [S-1:0]  mem_dout,
  output logic          mem_mread,
  output logic          mem_mwrite
);

  state_t        state_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          uns_q;
  logic [S-1:0]  wdata_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [S-1:0]  rsp_rdata_q;
  logic [AW-1:0] mem_a_q;
  logic [S-1:0]  mem_din_q;
  logic          mem_mread_q;
  logic          mem_mwrite_q;

  logic          err_d;
  logic [AW-1:0] wa_d;
  logic [S-1:0]  merged;
  logic [S-1:0]  extracted;

  assign err_d = bad_access(req_size, req_addr[1:0]) ||
                 ({2'b00, req_addr[31:2]} >= 32'(L));
  assign wa_d  = req_addr[AW+1:2];

  // Old word comes straight from the memory during READ; both the load
  // result and the merged store word are captured on the READ exit edge.
  dmem_lane #(.S(S)) u_lane (
    .old_i    (mem_dout),
    .new_i    (wdata_q),
    .size_i   (size_q),
    .off_i    (off_q),
    .uns_i    (uns_q),
    .merged_o (merged),
    .ext_o    (extracted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_a_q      <= '0;
      mem_din_q    <= '0;
      mem_mread_q  <= 1'b0;
      mem_mwrite_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (err_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (!req_we || (req_size != SZ_WORD)) begin
              state_q     <= ST_READ;
              mem_a_q     <= wa_d;
              mem_mread_q <= 1'b1;
            end else begin
              state_q      <= ST_WRITE;
              mem_a_q      <= wa_d;
              mem_din_q    <= req_wdata;
              mem_mwrite_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          mem_mread_q <= 1'b0;
          if (we_q) begin
            state_q      <= ST_WRITE;
            mem_din_q    <= merged;
            mem_mwrite_q <= 1'b1;
          end else begin
            state_q     <= ST_RESP;
            mem_a_q     <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= extracted;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_RESP;
          mem_mwrite_q <= 1'b0;
          mem_a_q      <= '0;
          mem_din_q    <= '0;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= '0;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_din    = mem_din_q;
  assign mem_mread  = mem_mread_q;
  assign mem_mwrite = mem_mwrite_q;

endmodule
